apple_1_emu_loader: RTL and testbench

//  Byte-stream download/upload engine driving the RAM-emulation port (emu_en/emu_clk/emu_addr/emu_we/emu_di/emu_do)
//  of the Apple-I WozMon+PIA+RAM32k top. Host bytes arrive on a valid/ready stream and are parsed as
//  W(rite)/R(ead)/G(o) commands, which become RAM strobes. While loading, emu_en takes the RAM away from the CPU.

---
 rtl/apple_1_emu_loader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_apple_1_emu_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_1_emu_loader.sv
// ============================================================================
//  Module   : apple_1_emu_loader
//  Purpose  : Host byte-stream W/R/G command engine driving the Apple-I RAM
//             emulation port. Optional feature macro: LOADER_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module apple_1_emu_loader #(
    parameter logic [7:0] CMD_WRITE = 8'h57,
    parameter logic [7:0] CMD_READ  = 8'h52,
    parameter logic [7:0] CMD_GO    = 8'h47,
    parameter logic [7:0] RSP_ACK   = 8'h06,
    parameter logic [7:0] RSP_NAK   = 8'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        emu_en,
    output logic        emu_clk,
    output logic [14:0] emu_addr,
    output logic        emu_we,
    output logic [7:0]  emu_di,
    input  logic [7:0]  emu_do
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR_H    = 4'd1,
        ST_ADDR_L    = 4'd2,
        ST_LEN       = 4'd3,
        ST_DATA      = 4'd4,
        ST_WR_SETUP  = 4'd5,
        ST_WR_STROBE = 4'd6,
        ST_RD_SETUP  = 4'd7,
        ST_RD_STROBE = 4'd8,
        ST_RD_SAMPLE = 4'd9,
        ST_TX        = 4'd10,
        ST_RESP      = 4'd11
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHK       = 4'd12,
        ST_TX_CHK    = 4'd13
`endif
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic        r_rx_ready, w_rx_ready_nxt;
    logic        r_tx_valid, w_tx_valid_nxt;
    logic [7:0]  r_tx_data,  w_tx_data_nxt;
    logic        r_emu_en,   w_emu_en_nxt;
    logic        r_emu_clk,  w_emu_clk_nxt;
    logic [14:0] r_addr,     w_addr_nxt;
    logic        r_emu_we,   w_emu_we_nxt;
    logic [7:0]  r_emu_di,   w_emu_di_nxt;
    logic [8:0]  r_cnt,      w_cnt_nxt;
    logic        r_is_read,  w_is_read_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum,      w_sum_nxt;
`endif

    logic w_rx_fire;
    logic w_tx_fire;
    logic w_last;

    assign w_rx_fire = rx_valid & r_rx_ready;
    assign w_tx_fire = r_tx_valid & tx_ready;
    assign w_last    = (r_cnt == 9'd1);

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_data_nxt  = r_tx_data;
        w_emu_en_nxt   = r_emu_en;
        w_emu_clk_nxt  = 1'b0;
        w_addr_nxt     = r_addr;
        w_emu_we_nxt   = r_emu_we;
        w_emu_di_nxt   = r_emu_di;
        w_cnt_nxt      = r_cnt;
        w_is_read_nxt  = r_is_read;
`ifdef LOADER_CHECKSUM_EN
        w_sum_nxt      = r_sum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        w_emu_en_nxt  = 1'b1;
                        w_is_read_nxt = (rx_data == CMD_READ);
                        w_state_nxt   = ST_ADDR_H;
                    end else begin
                        if (rx_data == CMD_GO) begin
                            w_emu_en_nxt = 1'b0;
                        end
                        w_tx_valid_nxt = 1'b1;
                        w_tx_data_nxt  = (rx_data == CMD_GO) ? RSP_ACK : RSP_NAK;
                        w_state_nxt    = ST_RESP;
                    end
                end
            end
            ST_ADDR_H: begin
                if (w_rx_fire) begin
                    w_addr_nxt[14:8] = rx_data[6:0];
                    w_state_nxt      = ST_ADDR_L;
                end
            end
            ST_ADDR_L: begin
                if (w_rx_fire) begin
                    w_addr_nxt[7:0] = rx_data;
                    w_state_nxt     = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_rx_fire) begin
                    // A zero length byte encodes a full 256-byte block
                    w_cnt_nxt   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt   = 8'd0;
`endif
                    w_state_nxt = r_is_read ? ST_RD_SETUP : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_rx_fire) begin
                    w_emu_di_nxt = rx_data;
                    w_emu_we_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    w_sum_nxt    = r_sum + rx_data;
`endif
                    w_state_nxt  = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                w_emu_clk_nxt = 1'b1;
                w_state_nxt   = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                w_emu_we_nxt = 1'b0;
                w_addr_nxt   = r_addr + 15'd1;
                w_cnt_nxt    = r_cnt - 9'd1;
                if (!w_last) begin
                    w_state_nxt = ST_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt    = ST_CHK;
`else
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = RSP_ACK;
                    w_state_nxt    = ST_RESP;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_rx_fire) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = (rx_data == r_sum) ? RSP_ACK : RSP_NAK;
                    w_state_nxt    = ST_RESP;
                end
            end
            ST_TX_CHK: begin
                if (w_tx_fire) begin
                    w_tx_data_nxt = RSP_ACK;
                    w_state_nxt   = ST_RESP;
                end
            end
`endif
            ST_RD_SETUP: begin
                w_emu_clk_nxt = 1'b1;
                w_emu_we_nxt  = 1'b0;
                w_state_nxt   = ST_RD_STROBE;
            end
            ST_RD_STROBE: begin
                w_state_nxt = ST_RD_SAMPLE;
            end
            ST_RD_SAMPLE: begin
                w_tx_data_nxt  = emu_do;
                w_tx_valid_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                w_sum_nxt      = r_sum + emu_do;
`endif
                w_state_nxt    = ST_TX;
            end
            ST_TX: begin
                if (w_tx_fire) begin
                    w_addr_nxt = r_addr + 15'd1;
                    w_cnt_nxt  = r_cnt - 9'd1;
                    if (!w_last) begin
                        w_tx_valid_nxt = 1'b0;
                        w_state_nxt    = ST_RD_SETUP;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        w_tx_data_nxt = r_sum;
                        w_state_nxt   = ST_TX_CHK;
`else
                        w_tx_data_nxt = RSP_ACK;
                        w_state_nxt   = ST_RESP;
`endif
                    end
                end
            end
            ST_RESP: begin
                if (w_tx_fire) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // rx_ready is registered, so it is decoded from the state being entered
        w_rx_ready_nxt = (w_state_nxt == ST_IDLE)   || (w_state_nxt == ST_ADDR_H) ||
                         (w_state_nxt == ST_ADDR_L) || (w_state_nxt == ST_LEN)    ||
`ifdef LOADER_CHECKSUM_EN
                         (w_state_nxt == ST_CHK)    ||
`endif
                         (w_state_nxt == ST_DATA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_emu_en   <= 1'b0;
            r_emu_clk  <= 1'b0;
            r_addr     <= 15'd0;
            r_emu_we   <= 1'b0;
            r_emu_di   <= 8'd0;
            r_cnt      <= 9'd0;
            r_is_read  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= w_rx_ready_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_emu_en   <= w_emu_en_nxt;
            r_emu_clk  <= w_emu_clk_nxt;
            r_addr     <= w_addr_nxt;
            r_emu_we   <= w_emu_we_nxt;
            r_emu_di   <= w_emu_di_nxt;
            r_cnt      <= w_cnt_nxt;
            r_is_read  <= w_is_read_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= w_sum_nxt;
`endif
        end
    end

    assign rx_ready = r_rx_ready;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign emu_en   = r_emu_en;
    assign emu_clk  = r_emu_clk;
    assign emu_addr = r_addr;
    assign emu_we   = r_emu_we;
    assign emu_di   = r_emu_di;

endmodule

`default_nettype wire

// File: tb/tb_apple_1_emu_loader.sv
// ============================================================================
//  Module   : tb_apple_1_emu_loader
//  Purpose  : Scoreboard bench for apple_1_emu_loader with a 32K RAM model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apple_1_emu_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        emu_en;
    logic        emu_clk;
    logic [14:0] emu_addr;
    logic        emu_we;
    logic [7:0]  emu_di;
    logic [7:0]  emu_do = 8'd0;

    apple_1_emu_loader dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .emu_en   (emu_en),
        .emu_clk  (emu_clk),
        .emu_addr (emu_addr),
        .emu_we   (emu_we),
        .emu_di   (emu_di),
        .emu_do   (emu_do)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:32767];
    int         strobes = 0;

    always @(posedge emu_clk) begin
        if (emu_we) mem[emu_addr] <= emu_di;
        emu_do  <= mem[emu_addr];
        strobes <= strobes + 1;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    logic [7:0] pl [$];
    int         hold_cnt = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output-side monitor: owns tx_ready, pops the scoreboard on each handshake
    logic       tx_pending = 1'b0;
    logic [7:0] held       = 8'd0;
    logic       prev_clk   = 1'b0;
    logic       prev_en    = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            tx_ready   = 1'b0;
            tx_pending = 1'b0;
            prev_clk   = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (prev_clk) chk_eq("emu_clk_single", {63'd0, emu_clk}, 64'd0);
            if (emu_en != prev_en) chk_eq("emu_en_no_strobe", {63'd0, emu_clk | prev_clk}, 64'd0);
            if (tx_pending) chk_eq("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, held});
            if (tx_valid) chk_eq("rx_ready_stall", {63'd0, rx_ready}, 64'd0);
            tx_ready = (hold_cnt == 0);
            if (hold_cnt > 0) hold_cnt--;
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    chk_eq("tx_unexpected", 64'(sb.size()), 64'd1);
                end else begin
                    chk_eq("tx_byte", {56'd0, tx_data}, {56'd0, sb.pop_front()});
                end
                tx_pending = 1'b0;
            end else begin
                tx_pending = tx_valid;
                held       = tx_data;
            end
            prev_clk = emu_clk;
            prev_en  = emu_en;
        end
    end

    // All tasks start and finish just after a falling edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk_eq("rx_timeout", 64'(n), 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk_eq("sb_drain", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] pl_sum();
        logic [7:0] s;
        s = 8'd0;
        foreach (pl[i]) s = s + pl[i];
        return s;
    endfunction

    task automatic write_frame(input logic [7:0] ah, input logic [7:0] al);
        logic [8:0] len9;
        len9 = 9'(pl.size());
        sb.push_back(8'h06);
        send_byte(8'h57);
        send_byte(ah);
        send_byte(al);
        send_byte(len9[7:0]);
        foreach (pl[i]) send_byte(pl[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(pl_sum());
`endif
    endtask

    task automatic read_frame(input logic [7:0] ah, input logic [7:0] al);
        logic [8:0] len9;
        len9 = 9'(pl.size());
        foreach (pl[i]) sb.push_back(pl[i]);
`ifdef LOADER_CHECKSUM_EN
        sb.push_back(pl_sum());
`endif
        sb.push_back(8'h06);
        send_byte(8'h52);
        send_byte(ah);
        send_byte(al);
        send_byte(len9[7:0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        chk_eq("reset_outputs",
               {28'd0, rx_ready, tx_valid, tx_data, emu_en, emu_clk, emu_addr, emu_we, emu_di},
               64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_eq("rx_ready_after_reset", {63'd0, rx_ready}, 64'd1);

        // Three-byte write at 0x0010
        pl = '{8'hA9, 8'h01, 8'h8D};
        s0 = strobes;
        write_frame(8'h00, 8'h10);
        wait_sb();
        chk_eq("wr3_strobes", 64'(strobes - s0), 64'd3);
        chk_eq("wr3_emu_en", {63'd0, emu_en}, 64'd1);
        chk_eq("ram_0010", {56'd0, mem[15'h0010]}, 64'hA9);
        chk_eq("ram_0011", {56'd0, mem[15'h0011]}, 64'h01);
        chk_eq("ram_0012", {56'd0, mem[15'h0012]}, 64'h8D);

        // Read back with bit7 of ADDR_H set and the first response stalled
        hold_cnt = 30;
        read_frame(8'h80, 8'h10);
        wait_sb();
        chk_eq("rd_addr_after", {49'd0, emu_addr}, 64'h0013);

        // Address wrap at the top of RAM
        pl = '{8'h11, 8'h22};
        write_frame(8'h7F, 8'hFF);
        wait_sb();
        chk_eq("ram_7fff", {56'd0, mem[15'h7FFF]}, 64'h11);
        chk_eq("ram_0000", {56'd0, mem[15'h0000]}, 64'h22);
        chk_eq("wrap_addr", {49'd0, emu_addr}, 64'h0001);

        // LEN=0 means a full 256-byte block
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i) ^ 8'h5A);
        s0 = strobes;
        write_frame(8'h01, 8'h00);
        wait_sb();
        chk_eq("len0_strobes", 64'(strobes - s0), 64'd256);
        chk_eq("ram_0100", {56'd0, mem[15'h0100]}, 64'h5A);
        chk_eq("ram_01ff", {56'd0, mem[15'h01FF]}, 64'hA5);
        chk_eq("len0_addr", {49'd0, emu_addr}, 64'h0200);

        // Unknown command leaves emu_en set, GO releases, unknown again keeps it clear
        sb.push_back(8'h15);
        send_byte(8'h5A);
        wait_sb();
        chk_eq("nak_keeps_en1", {63'd0, emu_en}, 64'd1);
        sb.push_back(8'h06);
        send_byte(8'h47);
        wait_sb();
        chk_eq("go_clears_en", {63'd0, emu_en}, 64'd0);
        sb.push_back(8'h15);
        send_byte(8'h5A);
        wait_sb();
        chk_eq("nak_keeps_en0", {63'd0, emu_en}, 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: writes commit, response is NAK
        sb.push_back(8'h15);
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h04);
        wait_sb();
        chk_eq("chk_bad_ram0", {56'd0, mem[15'h0000]}, 64'h01);
        chk_eq("chk_bad_ram1", {56'd0, mem[15'h0001]}, 64'h02);
`endif

        // Reset in the middle of a frame
        send_byte(8'h57);
        send_byte(8'h00);
        reset = 1'b0;
        @(negedge clk);
        chk_eq("midrst_outputs",
               {28'd0, rx_ready, tx_valid, tx_data, emu_en, emu_clk, emu_addr, emu_we, emu_di},
               64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_eq("midrst_rx_ready", {63'd0, rx_ready}, 64'd1);
        sb.push_back(8'h06);
        send_byte(8'h47);
        wait_sb();
        chk_eq("midrst_go_en", {63'd0, emu_en}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
